pcg_rr_scheduler: RTL
=====================

PCG_RR_SCHEDULER -- requirements
Module: pcg_rr_scheduler

Interface
REQ-001 The block SHALL expose parameter NUM_REQ, default 4, the number of requesters sharing one PCG generator (2..8).
REQ-002 The block SHALL expose parameter WARMUP, default 8, the number of LCG steps run after reset or reseed before any grant (0..255).
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  level request, one bit per requester.
REQ-006 gnt  output  NUM_REQ  registered one-hot grant; the data on rnd_data belongs to this requester.
REQ-007 rnd_data  output  16  PCG XSH-RR output, valid while any gnt bit is high.
REQ-008 rnd_id  output  clog2(NUM_REQ)  binary index of the granted requester.
REQ-009 busy  output  1  high while in WARMUP state.
REQ-010 seed_valid / seed  input  1 / 32  reseed strobe and value; present only under PCG_RESEED_EN (REQ-027).

Function
REQ-011 FSM states SHALL be WARMUP and RUN; reset SHALL enter WARMUP with warm-up counter = WARMUP.
REQ-012 WARMUP: LCG SHALL step every cycle, counter decrements, no grants; at counter 0 the FSM SHALL move to RUN (WARMUP=0 enters RUN on the first cycle after reset).
REQ-013 LCG step SHALL be state <= state * 32'h5851F42D + 32'h14057B7E, modulo 2^32.
REQ-014 Output SHALL be computed from the pre-step state s: x = bits[15:0] of (((s >> 10) ^ s) >> 12), rot = s[31:28], rnd_data = x rotated right by rot within 16 bits.
REQ-015 RUN: each cycle with any req bit high, the arbiter SHALL choose one requester round-robin, starting from (last_granted + 1) mod NUM_REQ.
REQ-016 Grant latency SHALL be one cycle: req sampled at edge N gives gnt, rnd_id and rnd_data registered at edge N+1.
REQ-017 The LCG SHALL step only on cycles that issue a grant in RUN, so each granted value is consumed exactly once.
REQ-018 A requester holding req high SHALL receive one value per grant; with all requests high, grants SHALL rotate 0,1,...,NUM_REQ-1,0.
REQ-019 No request in RUN SHALL give gnt = 0 next cycle, with rnd_data and rnd_id holding their last values and the LCG frozen.
REQ-020 last_granted SHALL reset to NUM_REQ-1, so requester 0 has first priority.
REQ-021 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-022 busy SHALL equal (state == WARMUP).

Reset
REQ-023 On rst_n low, the block SHALL immediately set LCG state = 32'h0, gnt = 0, rnd_data = 0, rnd_id = 0, busy = 1 and last_granted = NUM_REQ-1.
REQ-024 Reset asserted mid-grant SHALL clear gnt in the same instant; no grant SHALL be issued until WARMUP completes after release.
REQ-025 Reset release SHALL take effect on the first rising clk edge after rst_n goes high.

Configuration
REQ-026 Without PCG_RESEED_EN, the seed ports SHALL be absent and the LCG SHALL start only from reset value 0.
REQ-027 With PCG_RESEED_EN, seed_valid high at an edge SHALL load state <= seed, reload the warm-up counter, enter WARMUP and force gnt = 0 next cycle.
REQ-028 Under PCG_RESEED_EN, seed_valid SHALL have priority over a simultaneous grant; the losing request SHALL stay pending and the round-robin pointer SHALL stay unchanged.

Structure
REQ-029 A shared package pcg_pkg SHALL hold PCG_MULT, PCG_INC, the FSM state enum, and the pure function pcg_xsh_rr16(s).
REQ-030 The design SHALL have one sub-module, rr_arbiter (NUM_REQ-parameterised, combinational pick plus a registered pointer); the LCG and FSM SHALL stay in the top module.

Verification
REQ-031 WARMUP=1, reset, req=4'b0001 held -> busy high 1 cycle; first gnt=4'b0001, rnd_id=0, rnd_data=16'hA003.
REQ-032 WARMUP=0, req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... with no idle cycles.
REQ-033 RUN, req dropped to 0 for 3 cycles -> gnt=0 and rnd_data frozen; next grant value equals the value that would have followed the last one with no gap.
REQ-034 rst_n pulsed low while gnt=4'b0100 -> gnt=0 asynchronously; after release busy=1 for WARMUP cycles; first grant goes to the lowest active req.
REQ-035 PCG_RESEED_EN, WARMUP=1: seed=32'h0 and req=4'b0010 on the same edge -> no grant next cycle, busy=1; then gnt=4'b0010 with rnd_data=16'hA003.
REQ-036 A randomised bench SHALL check every rnd_data against a reference model of REQ-013/REQ-014 and check that gnt is always one-hot or zero.

Source files
------------

// File: rtl/pcg_rr_scheduler_pkg.sv
// Shared constants, FSM state type and PCG helper functions for pcg_rr_scheduler.
package pcg_pkg;

    localparam logic [31:0] PCG_MULT = 32'h5851F42D;
    localparam logic [31:0] PCG_INC  = 32'h14057B7E;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } pcg_state_e;

    function automatic logic [31:0] pcg_lcg_step(input logic [31:0] s);
        return s * PCG_MULT + PCG_INC;
    endfunction

    // Rotating the doubled word right leaves the rotated value in the low half.
    function automatic logic [15:0] pcg_xsh_rr16(input logic [31:0] s);
        logic [31:0] w_mix;
        logic [31:0] w_dbl;
        w_mix = ((s >> 10) ^ s) >> 12;
        w_dbl = {w_mix[15:0], w_mix[15:0]} >> s[31:28];
        return w_dbl[15:0];
    endfunction

endpackage

// File: rtl/pcg_rr_scheduler_if.sv
// Request/grant/data bundle of pcg_rr_scheduler; seed signals exist only when PCG_RESEED_EN is defined.
interface pcg_rr_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [15:0]        rnd_data;
    logic [IW-1:0]      rnd_id;
    logic               busy;
`ifdef PCG_RESEED_EN
    logic               seed_valid;
    logic [31:0]        seed;

    modport master (output req, output seed_valid, output seed,
                    input gnt, input rnd_data, input rnd_id, input busy);
    modport slave  (input req, input seed_valid, input seed,
                    output gnt, output rnd_data, output rnd_id, output busy);
`else
    modport master (output req, input gnt, input rnd_data, input rnd_id, input busy);
    modport slave  (input req, output gnt, output rnd_data, output rnd_id, output busy);
`endif

endinterface

// File: rtl/pcg_rr_scheduler_rr_arbiter.sv
// Round-robin pick among NUM_REQ requesters; the registered pointer holds the last granted index.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_update,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_valid
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] r_last;
    logic [IW-1:0] w_cand;
    logic [IW-1:0] w_idx;
    logic          w_valid;

    // Scan from the farthest offset down so the nearest requester after r_last wins.
    always_comb begin
        w_valid = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = IW'((int'(r_last) + i) % NUM_REQ);
            if (i_req[w_cand]) begin
                w_valid = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IW'(NUM_REQ - 1);
        end else if (i_update) begin
            r_last <= w_idx;
        end
    end

    assign o_idx   = w_idx;
    assign o_valid = w_valid;

endmodule

// File: rtl/pcg_rr_scheduler.sv
// One PCG XSH-RR generator shared round-robin among NUM_REQ requesters.
// Optional reseed port enabled by defining PCG_RESEED_EN.
module pcg_rr_scheduler
    import pcg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WARMUP  = 8
) (
    input logic               clk,
    input logic               rst_n,
    pcg_rr_scheduler_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    pcg_state_e         r_state;
    pcg_state_e         w_nextState;
    logic [7:0]         r_warmCnt;
    logic [7:0]         w_warmCntNext;
    logic [31:0]        r_lcg;
    logic [31:0]        w_lcgNext;
    logic               w_grant;
    logic               w_arbValid;
    logic [IW-1:0]      w_arbIdx;
    logic [NUM_REQ-1:0] r_gnt;
    logic [15:0]        r_rndData;
    logic [IW-1:0]      r_rndId;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (bus.req),
        .i_update (w_grant),
        .o_idx    (w_arbIdx),
        .o_valid  (w_arbValid)
    );

    // The LCG only advances on warm-up steps and on cycles that consume a value.
    always_comb begin
        w_nextState   = r_state;
        w_warmCntNext = r_warmCnt;
        w_lcgNext     = r_lcg;
        w_grant       = 1'b0;
        case (r_state)
            ST_WARMUP: begin
                if (r_warmCnt == 8'd0) begin
                    w_nextState = ST_RUN;
                end else begin
                    w_lcgNext     = pcg_lcg_step(r_lcg);
                    w_warmCntNext = r_warmCnt - 8'd1;
                    if (r_warmCnt == 8'd1) begin
                        w_nextState = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_arbValid) begin
                    w_grant   = 1'b1;
                    w_lcgNext = pcg_lcg_step(r_lcg);
                end
            end
            default: w_nextState = ST_WARMUP;
        endcase
`ifdef PCG_RESEED_EN
        if (bus.seed_valid) begin
            w_grant       = 1'b0;
            w_lcgNext     = bus.seed;
            w_warmCntNext = 8'(WARMUP);
            w_nextState   = ST_WARMUP;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_WARMUP;
            r_warmCnt <= 8'(WARMUP);
            r_lcg     <= 32'h0;
        end else begin
            r_state   <= w_nextState;
            r_warmCnt <= w_warmCntNext;
            r_lcg     <= w_lcgNext;
        end
    end

    // Data and id hold their last values on idle cycles; only gnt returns to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= '0;
            r_rndData <= 16'h0;
            r_rndId   <= '0;
        end else begin
            r_gnt <= '0;
            if (w_grant) begin
                r_gnt     <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << w_arbIdx;
                r_rndData <= pcg_xsh_rr16(r_lcg);
                r_rndId   <= w_arbIdx;
            end
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.rnd_data = r_rndData;
    assign bus.rnd_id   = r_rndId;
    assign bus.busy     = (r_state == ST_WARMUP);

endmodule
